accel_poll_sequencer: RTL and testbench

ACCEL_POLL_SEQUENCER -- requirements
Module: accel_poll_sequencer

---
 rtl/spi_pkg.sv | 36 +++
 rtl/poll_tick_gen.sv | 35 +++
 rtl/accel_poll_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_accel_poll_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the accelerometer poll sequencer: state encoding,
// power-up configuration table and the burst-read command.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StCfgAddr  = 3'd0;
  localparam state_t StCfgData  = 3'd1;
  localparam state_t StWaitTick = 3'd2;
  localparam state_t StRdCmd    = 3'd3;
  localparam state_t StRdByte   = 3'd4;
  localparam state_t StUpdate   = 3'd5;
  localparam state_t StIdle     = 3'd6;

  // Read, multi-byte, starting at DATAX0 (0x32).
  localparam logic [7:0] READ_CMD = 8'hF2;
  localparam int unsigned DATA_BYTES = 6;

  // Write frames need bit7 (read) and bit6 (multi-byte) clear.
  function automatic logic [7:0] cfg_addr(input int unsigned idx);
    case (idx)
      0:       return 8'h31;  // DATA_FORMAT
      1:       return 8'h2D;  // POWER_CTL
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] cfg_data(input int unsigned idx);
    case (idx)
      0:       return 8'h0B;
      1:       return 8'h08;  // measure mode
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running poll divider; counts only while run_i is high and emits a
// one-cycle tick on terminal count.
module poll_tick_gen #(
  parameter int unsigned POLL_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(POLL_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == CntW'(POLL_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/accel_poll_sequencer.sv
// Drives an SPI byte engine: writes the power-up configuration once, then
// burst-reads the X/Y/Z sample registers on every poll tick.
module accel_poll_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned POLL_DIV  = 500000,
  parameter int unsigned CFG_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  output logic        xfer_last,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned CfgIdxW = (CFG_COUNT > 1) ? $clog2(CFG_COUNT) : 1;

  state_t                        state_q, state_d;
  logic                          wait_q, wait_d;
  logic                          busy_q, busy_d;
  logic                          cfg_done_q, cfg_done_d;
  logic                          pending_q, pending_d;
  logic [CfgIdxW-1:0]            cfg_idx_q, cfg_idx_d;
  logic [2:0]                    byte_idx_q, byte_idx_d;
  logic [DATA_BYTES-2:0][7:0]    shadow_q, shadow_d;
  logic [15:0]                   x_q, x_d, y_q, y_d, z_q, z_d;
  logic                          start_q, start_d, last_q, last_d, valid_q, valid_d;
  logic [7:0]                    tx_q, tx_d;
  logic                          tick, done_ok, launch;

  poll_tick_gen #(
    .POLL_DIV (POLL_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .run_i  (enable && cfg_done_q),
    .tick_o (tick)
  );

  // A done pulse only counts when we actually have a byte in flight.
  assign done_ok = xfer_done && wait_q;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    busy_d     = busy_q;
    cfg_done_d = cfg_done_q;
    pending_d  = pending_q;
    cfg_idx_d  = cfg_idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    start_d    = 1'b0;
    tx_d       = 8'h00;
    last_d     = 1'b0;
    valid_d    = 1'b0;
    launch     = 1'b0;

    if (tick && (state_q == StRdCmd || state_q == StRdByte)) pending_d = 1'b1;
    if (!enable) pending_d = 1'b0;

    case (state_q)
      StCfgAddr: begin
        if (!wait_q) begin
          start_d = 1'b1;
          tx_d    = cfg_addr(32'(cfg_idx_q));
          wait_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (done_ok) begin
          state_d = StCfgData;
          start_d = 1'b1;
          tx_d    = cfg_data(32'(cfg_idx_q));
          last_d  = 1'b1;
        end
      end
      StCfgData: begin
        if (done_ok) begin
          wait_d = 1'b0;
          busy_d = 1'b0;
          if (cfg_idx_q == CfgIdxW'(CFG_COUNT - 1)) begin
            cfg_done_d = 1'b1;
            state_d    = enable ? StWaitTick : StIdle;
          end else begin
            cfg_idx_d = cfg_idx_q + CfgIdxW'(1);
            state_d   = StCfgAddr;
          end
        end
      end
      StWaitTick: begin
        if (!enable)   state_d = StIdle;
        else if (tick) launch  = 1'b1;
      end
      StRdCmd: begin
        if (done_ok) begin
          state_d    = StRdByte;
          byte_idx_d = 3'd0;
          start_d    = 1'b1;
        end
      end
      StRdByte: begin
        if (done_ok) begin
          if (byte_idx_q == 3'(DATA_BYTES - 1)) begin
            // Final byte goes straight into Z so all three axes load together.
            wait_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = StUpdate;
            x_d     = {shadow_q[1], shadow_q[0]};
            y_d     = {shadow_q[3], shadow_q[2]};
            z_d     = {xfer_rx, shadow_q[4]};
            valid_d = 1'b1;
          end else begin
            shadow_d[byte_idx_q] = xfer_rx;
            byte_idx_d           = byte_idx_q + 3'd1;
            start_d              = 1'b1;
            last_d               = (byte_idx_q == 3'(DATA_BYTES - 2));
          end
        end
      end
      StUpdate: begin
        if (!enable) begin
          state_d   = StIdle;
          pending_d = 1'b0;
        end else if (pending_q || tick) begin
          launch = 1'b1;
        end else begin
          state_d = StWaitTick;
        end
      end
      StIdle: begin
        if (enable) state_d = StWaitTick;
      end
      default: state_d = StCfgAddr;
    endcase

    if (launch) begin
      state_d   = StRdCmd;
      start_d   = 1'b1;
      tx_d      = READ_CMD;
      wait_d    = 1'b1;
      busy_d    = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCfgAddr;
      wait_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      pending_q  <= 1'b0;
      cfg_idx_q  <= '0;
      byte_idx_q <= 3'd0;
      shadow_q   <= '0;
      x_q        <= 16'h0000;
      y_q        <= 16'h0000;
      z_q        <= 16'h0000;
      start_q    <= 1'b0;
      tx_q       <= 8'h00;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      pending_q  <= pending_d;
      cfg_idx_q  <= cfg_idx_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign xfer_start = start_q;
  assign xfer_tx    = tx_q;
  assign xfer_last  = last_q;
  assign x_data     = x_q;
  assign y_data     = y_q;
  assign z_data     = z_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Directed bench for accel_poll_sequencer with a scripted SPI byte engine model.
module tb_accel_poll_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        xfer_start, xfer_last, xfer_done, data_valid, busy;
  logic [7:0]  xfer_tx, xfer_rx;
  logic [15:0] x_data, y_data, z_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int unsigned cyc = 0;
  int unsigned delay = 8;
  int unsigned rem = 0;
  bit          eng_busy = 1'b0;
  bit          spur_req = 1'b0;
  int unsigned overlap_err = 0;
  logic [7:0]  rx_q[$];
  logic [8:0]  tx_log[$];
  int unsigned start_cyc[$];
  int unsigned valid_cnt = 0;
  int unsigned valid_cyc[$];
  logic        busy_at_valid = 1'b1;

  accel_poll_sequencer #(
    .POLL_DIV  (64),
    .CFG_COUNT (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .xfer_start (xfer_start),
    .xfer_tx    (xfer_tx),
    .xfer_last  (xfer_last),
    .xfer_done  (xfer_done),
    .xfer_rx    (xfer_rx),
    .x_data     (x_data),
    .y_data     (y_data),
    .z_data     (z_data),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte engine: done 'delay' cycles after start, rx from the script queue.
  initial begin
    xfer_done = 1'b0;
    xfer_rx   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      xfer_done = 1'b0;
      if (rst) begin
        eng_busy = 1'b0;
      end else begin
        if (xfer_start && eng_busy) overlap_err++;
        if (eng_busy) begin
          rem--;
          if (rem == 0) begin
            xfer_done = 1'b1;
            xfer_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hAA;
            eng_busy  = 1'b0;
          end
        end else if (spur_req) begin
          xfer_done = 1'b1;
          xfer_rx   = 8'h5A;
          spur_req  = 1'b0;
        end
        if (xfer_start) begin
          tx_log.push_back({xfer_last, xfer_tx});
          start_cyc.push_back(cyc);
          eng_busy = 1'b1;
          rem      = delay;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (data_valid) begin
        valid_cnt++;
        valid_cyc.push_back(cyc);
        busy_at_valid = busy;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_log(input int unsigned n, input int budget, input string tag);
    int i = 0;
    while (tx_log.size() < n && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input int unsigned n, input int budget, input string tag);
    int i = 0;
    while (valid_cnt < n && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(valid_cnt >= n), 32'd1);
  endtask

  initial begin
    int unsigned rel, en_at, base;

    // Reset values
    step(3);
    chk("rst_start", 32'(xfer_start), 32'd0);
    chk("rst_tx", 32'(xfer_tx), 32'h00);
    chk("rst_last", 32'(xfer_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_xyz", {x_data, y_data | z_data}, 32'h0);

    // Config then first poll frame
    rx_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h80};
    rst = 1'b0;
    rel = cyc;
    wait_log(4, 200, "cfg_timeout");
    chk("cfg_first_start", start_cyc[0], rel + 1);
    chk("cfg_b0", 32'(tx_log[0]), 32'h031);
    chk("cfg_b1", 32'(tx_log[1]), 32'h10B);
    chk("cfg_b2", 32'(tx_log[2]), 32'h02D);
    chk("cfg_b3", 32'(tx_log[3]), 32'h108);
    chk("cfg_gap_in_frame", start_cyc[1] - start_cyc[0], 32'd9);
    chk("cfg_gap_between", start_cyc[2] - start_cyc[1], 32'd10);

    wait_log(11, 300, "poll1_timeout");
    chk("poll1_first", start_cyc[4] - start_cyc[0], 32'd101);
    chk("poll1_cmd", 32'(tx_log[4]), 32'h0F2);
    for (int k = 5; k < 11; k++) begin
      chk($sformatf("poll1_b%0d", k - 4), 32'(tx_log[k]), (k == 10) ? 32'h100 : 32'h000);
      chk($sformatf("poll1_gap%0d", k - 4), start_cyc[k] - start_cyc[k-1], 32'd9);
    end
    wait_valid(1, 200, "valid1_timeout");
    chk("valid1_time", valid_cyc[0], start_cyc[10] + 9);
    chk("valid1_busy", 32'(busy_at_valid), 32'd0);
    chk("x1", 32'(x_data), 32'h1234);
    chk("y1", 32'(y_data), 32'hFFFF);
    chk("z1", 32'(z_data), 32'h8000);

    // Frame 2: enable dropped after third data byte
    rx_q = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'h00, 8'hFE, 8'hFF};
    step(3);
    chk("valid1_one_cycle", 32'(valid_cnt), 32'd1);
    wait_log(12, 100, "poll2_timeout");
    chk("poll2_start", start_cyc[11], start_cyc[10] + 10);
    wait_log(15, 200, "poll2_b3_timeout");
    enable = 1'b0;
    wait_valid(2, 200, "valid2_timeout");
    chk("poll2_len", 32'(tx_log.size()), 32'd18);
    chk("x2", 32'(x_data), 32'h8001);
    chk("y2", 32'(y_data), 32'h007F);
    chk("z2", 32'(z_data), 32'hFFFE);
    step(20);
    spur_req = 1'b1;
    step(200);
    chk("idle_no_start", 32'(tx_log.size()), 32'd18);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid_cnt", 32'(valid_cnt), 32'd2);

    // Re-enable with a slow engine: frames overrun the poll period
    delay = 100;
    enable = 1'b1;
    en_at = cyc;
    wait_log(19, 100, "reen_timeout");
    chk("reen_latency", start_cyc[18], en_at + 64);
    chk("reen_cmd", 32'(tx_log[18]), 32'h0F2);
    wait_log(33, 2000, "overrun_timeout");
    chk("overrun_gap1", start_cyc[25] - start_cyc[18], 32'd708);
    chk("overrun_gap2", start_cyc[32] - start_cyc[25], 32'd708);
    chk("overrun_cmd", 32'(tx_log[32]), 32'h0F2);
    chk("overrun_valid_cnt", 32'(valid_cnt), 32'd4);
    chk("no_double_start", overlap_err, 32'd0);

    // Reset in the middle of frame 5
    wait_log(35, 400, "mid_timeout");
    step(20);
    rst = 1'b1;
    step(1);
    chk("midrst_start", 32'(xfer_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_xyz", {x_data, y_data | z_data}, 32'h0);
    rx_q.delete();
    delay = 8;
    base = tx_log.size();
    step(1);
    rst = 1'b0;
    rel = cyc;
    wait_log(base + 4, 200, "recfg_timeout");
    chk("recfg_first_start", start_cyc[base], rel + 1);
    chk("recfg_b0", 32'(tx_log[base]), 32'h031);
    chk("recfg_b1", 32'(tx_log[base+1]), 32'h10B);
    chk("recfg_b2", 32'(tx_log[base+2]), 32'h02D);
    chk("recfg_b3", 32'(tx_log[base+3]), 32'h108);
    step(12);
    chk("midrst_no_valid", 32'(valid_cnt), 32'd4);
    chk("final_no_double_start", overlap_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
